sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_burst_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - Burst read/write controller for an asynchronous SRAM
module sram_burst_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int T_SETUP = 2,
    parameter int T_WE    = 2,
    parameter int T_RD    = 3
) (
    input  logic              CLK1,
    input  logic              RST,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_pop,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              Ram1_EN,
    output logic              Ram1_OE,
    output logic              Ram1_WE,
    output logic [ADDR_W-1:0] Ram1_address,
    inout  wire  [DATA_W-1:0] Ram1_data,
    output logic              rdn,
    output logic              wrn
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT,
        NEXT,
        FIN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   remain;
    logic               wr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               drive;
    logic               rv_r;

    assign rdn = 1'b1;
    assign wrn = 1'b1;

    // Bus is only ever driven from the captured word, so it cannot move under a WE-low pulse.
    assign Ram1_data   = drive ? wdata_r : {DATA_W{1'bz}};
    assign rdata_valid = rv_r;

    always_ff @(posedge CLK1 or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= '0;
            remain       <= '0;
            wr_r         <= 1'b0;
            wdata_r      <= '0;
            rdata        <= '0;
            rv_r         <= 1'b0;
            Ram1_address <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            rv_r  <= 1'b0;
            if (state == IDLE && req) begin
                Ram1_address <= addr;
                remain       <= len;
                wr_r         <= wr;
            end
            if (state_n == W_SETUP && state != W_SETUP) begin
                wdata_r <= wdata;
            end
            if (state == R_WAIT && cnt == CNT_W'(T_RD - 1)) begin
                rdata <= Ram1_data;
                rv_r  <= 1'b1;
            end
            if (state == NEXT) begin
                Ram1_address <= Ram1_address + 1'b1;
                remain       <= remain - 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (len == '0) begin
                        state_n = FIN;
                    end else if (wr) begin
                        state_n = W_SETUP;
                    end else begin
                        state_n = R_WAIT;
                    end
                end
            end
            W_SETUP: begin
                if (cnt == CNT_W'(T_SETUP - 1)) state_n = W_PULSE;
            end
            W_PULSE: begin
                if (cnt == CNT_W'(T_WE - 1)) state_n = W_HOLD;
            end
            W_HOLD: state_n = NEXT;
            R_WAIT: begin
                if (cnt == CNT_W'(T_RD - 1)) state_n = NEXT;
            end
            NEXT: begin
                if (remain == LEN_W'(1)) begin
                    state_n = FIN;
                end else if (wr_r) begin
                    state_n = W_SETUP;
                end else begin
                    state_n = R_WAIT;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes decode straight from the state flop so an async reset releases them at once.
    always_comb begin
        Ram1_EN   = 1'b1;
        Ram1_OE   = 1'b1;
        Ram1_WE   = 1'b1;
        drive     = 1'b0;
        wdata_pop = 1'b0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            W_SETUP: begin
                Ram1_EN   = 1'b0;
                drive     = 1'b1;
                wdata_pop = (cnt == '0);
            end
            W_PULSE: begin
                Ram1_EN = 1'b0;
                Ram1_WE = 1'b0;
                drive   = 1'b1;
            end
            W_HOLD: begin
                Ram1_EN = 1'b0;
                drive   = 1'b1;
            end
            R_WAIT: begin
                Ram1_EN = 1'b0;
                Ram1_OE = 1'b0;
            end
            default: begin
                Ram1_EN = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - Directed self-checking bench for sram_burst_ctrl
module tb_sram_burst_ctrl;

    logic        CLK1;
    logic        RST;
    logic        req;
    logic        wr;
    logic [17:0] addr;
    logic [7:0]  len;
    logic [15:0] wdata;
    logic        wdata_pop;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        Ram1_EN;
    logic        Ram1_OE;
    logic        Ram1_WE;
    logic [17:0] Ram1_address;
    wire  [15:0] Ram1_data;
    logic        rdn;
    logic        wrn;

    int total = 0;
    int bad   = 0;

    sram_burst_ctrl dut (
        .CLK1(CLK1), .RST(RST), .req(req), .wr(wr), .addr(addr), .len(len),
        .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .done(done), .Ram1_EN(Ram1_EN), .Ram1_OE(Ram1_OE), .Ram1_WE(Ram1_WE),
        .Ram1_address(Ram1_address), .Ram1_data(Ram1_data), .rdn(rdn), .wrn(wrn)
    );

    initial begin
        CLK1 = 1'b0;
        forever #5 CLK1 = ~CLK1;
    end

    // Released bus reads back as all ones through the pull-ups.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (Ram1_data[g]);
    end

    logic [15:0] mem [0:262143];
    assign Ram1_data = (Ram1_EN === 1'b0 && Ram1_OE === 1'b0 && Ram1_WE === 1'b1)
                       ? mem[Ram1_address] : 16'bz;
    always @(posedge Ram1_WE) begin
        if (Ram1_EN === 1'b0) mem[Ram1_address] = Ram1_data;
    end

    logic [15:0] src [0:31];
    int          src_idx = 0;
    assign wdata = src[src_idx[4:0]];
    always @(posedge CLK1) begin
        if (wdata_pop === 1'b1) src_idx <= src_idx + 1;
    end

    int busy_cnt, done_cnt, pop_cnt, en_low, stable_bad, bus_bad;
    bit rd_chk = 0;
    logic we_prev = 1'b1, oe_prev = 1'b1;
    logic [17:0] w_a;
    logic [15:0] w_d;
    int w_len, o_len;
    int wa_q[$], wd_q[$], wl_q[$], ol_q[$], rv_q[$];

    always @(negedge CLK1) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (wdata_pop === 1'b1) pop_cnt++;
        if (Ram1_EN === 1'b0) en_low++;
        if (rdata_valid === 1'b1) rv_q.push_back(int'(rdata));
        if (Ram1_WE === 1'b0) begin
            if (we_prev === 1'b1) begin
                w_a = Ram1_address; w_d = Ram1_data; w_len = 0;
            end
            w_len++;
            if (Ram1_address !== w_a || Ram1_data !== w_d) stable_bad++;
        end else if (we_prev === 1'b0) begin
            wa_q.push_back(int'(w_a)); wd_q.push_back(int'(w_d)); wl_q.push_back(w_len);
        end
        if (Ram1_OE === 1'b0) begin
            if (oe_prev === 1'b1) o_len = 0;
            o_len++;
        end else if (oe_prev === 1'b0) begin
            ol_q.push_back(o_len);
        end
        if (rd_chk) begin
            if (Ram1_OE === 1'b0 && Ram1_data !== mem[Ram1_address]) bus_bad++;
            if (Ram1_OE === 1'b1 && Ram1_data !== 16'hFFFF) bus_bad++;
        end
        we_prev = Ram1_WE;
        oe_prev = Ram1_OE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0; done_cnt = 0; pop_cnt = 0; en_low = 0; stable_bad = 0; bus_bad = 0;
        wa_q.delete(); wd_q.delete(); wl_q.delete(); ol_q.delete(); rv_q.delete();
    endtask

    task automatic start(input logic w, input logic [17:0] a, input logic [7:0] l);
        @(posedge CLK1); #1;
        req = 1'b1; wr = w; addr = a; len = l;
        @(posedge CLK1); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge CLK1); #1;
            n++;
        end
        if (n >= budget) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge CLK1); #1;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
        for (int i = 0; i < 32; i++) src[i] = 16'h0;
        RST = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; len = '0;
        #2;
        chk("rst_en", Ram1_EN, 1); chk("rst_oe", Ram1_OE, 1); chk("rst_we", Ram1_WE, 1);
        chk("rst_addr", Ram1_address, 0); chk("rst_rdata", rdata, 0);
        chk("rst_rv", rdata_valid, 0); chk("rst_pop", wdata_pop, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_bus", Ram1_data, 16'hFFFF); chk("rst_rdn", rdn, 1); chk("rst_wrn", wrn, 1);
        repeat (2) @(posedge CLK1);
        #1 RST = 1'b1;

        // Three-word write at 0x10
        src[0] = 16'hA000; src[1] = 16'hA001; src[2] = 16'hA002;
        clear_mon();
        start(1'b1, 18'h00010, 8'd3);
        wait_idle(100);
        chk("wr_windows", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("wr_win_addr", wa_q[i], 32'h10 + i);
            chk("wr_win_data", wd_q[i], 32'hA000 + i);
            chk("wr_win_len", wl_q[i], 2);
        end
        chk("wr_pops", pop_cnt, 3); chk("wr_dones", done_cnt, 1);
        chk("wr_busy_cycles", busy_cnt, 3 * (2 + 2 + 2) + 1);
        chk("wr_stable", stable_bad, 0);
        chk("wr_mem12", mem[18'h12], 16'hA002);

        // Read the same range back
        clear_mon();
        rd_chk = 1;
        start(1'b0, 18'h00010, 8'd3);
        wait_idle(100);
        rd_chk = 0;
        chk("rd_valids", rv_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("rd_data", rv_q[i], 32'hA000 + i);
            chk("rd_oe_len", ol_q[i], 3);
        end
        chk("rd_bus", bus_bad, 0); chk("rd_pops", pop_cnt, 0); chk("rd_dones", done_cnt, 1);
        chk("rd_busy_cycles", busy_cnt, 3 * (3 + 1) + 1);
        chk("rd_last", rdata, 16'hA002);

        // Address wrap-around
        src[3] = 16'hB000; src[4] = 16'hB001;
        clear_mon();
        start(1'b1, 18'h3FFFF, 8'd2);
        wait_idle(100);
        chk("wrap_windows", wa_q.size(), 2);
        chk("wrap_addr0", wa_q[0], 32'h3FFFF); chk("wrap_addr1", wa_q[1], 32'h0);
        chk("wrap_mem_top", mem[18'h3FFFF], 16'hB000); chk("wrap_mem_zero", mem[0], 16'hB001);

        // Zero-length burst
        clear_mon();
        @(posedge CLK1); #1;
        req = 1'b1; wr = 1'b1; addr = 18'h00100; len = 8'd0;
        @(negedge CLK1); #1;
        chk("len0_done_early", done, 0);
        @(posedge CLK1); #1;
        req = 1'b0;
        @(negedge CLK1); #1;
        chk("len0_done", done, 1); chk("len0_busy", busy, 1);
        @(negedge CLK1); #1;
        chk("len0_done_clear", done, 0); chk("len0_idle", busy, 0);
        chk("len0_en", en_low, 0); chk("len0_pops", pop_cnt, 0); chk("len0_dones", done_cnt, 1);

        // req held high, then a stray pulse while busy
        src[5] = 16'hC000; src[6] = 16'hC001;
        clear_mon();
        @(posedge CLK1); #1;
        req = 1'b1; wr = 1'b1; addr = 18'h00040; len = 8'd2;
        repeat (6) begin @(posedge CLK1); #1; end
        req = 1'b0;
        repeat (3) begin @(posedge CLK1); #1; end
        req = 1'b1; addr = 18'h00200; len = 8'd1;
        @(posedge CLK1); #1;
        req = 1'b0;
        wait_idle(100);
        repeat (3) @(negedge CLK1);
        #1;
        chk("held_windows", wa_q.size(), 2);
        chk("held_addr0", wa_q[0], 32'h40); chk("held_addr1", wa_q[1], 32'h41);
        chk("held_dones", done_cnt, 1); chk("held_busy_cycles", busy_cnt, 13);
        chk("held_after", busy, 0);

        // Reset while WE is low
        src[7] = 16'hD000; src[8] = 16'hD001; src[9] = 16'hD002;
        clear_mon();
        start(1'b1, 18'h00080, 8'd3);
        begin
            int n = 0;
            while (Ram1_WE !== 1'b0 && n < 20) begin @(negedge CLK1); n++; end
            chk("rst_we_seen", Ram1_WE, 0);
        end
        #1 RST = 1'b0;
        #1;
        chk("arst_we", Ram1_WE, 1); chk("arst_en", Ram1_EN, 1); chk("arst_oe", Ram1_OE, 1);
        chk("arst_bus", Ram1_data, 16'hFFFF); chk("arst_busy", busy, 0);
        chk("arst_addr", Ram1_address, 0); chk("arst_pop", wdata_pop, 0);
        done_cnt = 0;
        repeat (3) @(posedge CLK1);
        #1;
        chk("arst_no_done", done_cnt, 0); chk("arst_still_idle", busy, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
